// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data RAM: CPU MEM stage vs debug port.
// CPU wins conflicts except for a forced debug slot after repeated starvation.
module dmem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic [3:0]        dbg_be,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       conflict_count
);

  typedef enum logic {PRI_CPU, PRI_DBG} pri_t;
  typedef enum logic [1:0] {
    OWN_NONE, OWN_CPU, OWN_DBG
  } own_t;

  pri_t        state;
  own_t        owner;
  logic [7:0]  starve_cnt;
  logic [31:0] conflict_q;
  logic        conflict;

  assign conflict = cpu_req & dbg_req;

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst) begin
      unique case (1'b1)
        conflict: begin
          cpu_gnt = (state == PRI_CPU);
          dbg_gnt = (state == PRI_DBG);
        end
        default: begin
          cpu_gnt = cpu_req;
          dbg_gnt = dbg_req;
        end
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign mem_en    = cpu_gnt | dbg_gnt;
  assign mem_we    = dbg_gnt ? dbg_we : (cpu_gnt & cpu_we);
  assign mem_addr  = dbg_gnt ? dbg_addr : cpu_addr;
  assign mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
  assign mem_be    = dbg_gnt ? dbg_be : cpu_be;

  // Forced debug slot is used or forfeited in one cycle either way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PRI_CPU;
      starve_cnt <= 8'd0;
    end else begin
      case (state)
        PRI_CPU: begin
          if (conflict && cpu_gnt) begin
            if (starve_cnt + 8'd1 == 8'(STARVE_LIMIT)) begin
              state      <= PRI_DBG;
              starve_cnt <= 8'd0;
            end else begin
              starve_cnt <= starve_cnt + 8'd1;
            end
          end else if (dbg_gnt || !dbg_req) begin
            starve_cnt <= 8'd0;
          end
        end
        PRI_DBG: begin
          if (dbg_gnt || !dbg_req) begin
            state      <= PRI_CPU;
            starve_cnt <= 8'd0;
          end
        end
        default: state <= PRI_CPU;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= OWN_NONE;
    end else begin
      unique case (1'b1)
        cpu_gnt && !cpu_we: owner <= OWN_CPU;
        dbg_gnt && !dbg_we: owner <= OWN_DBG;
        default:            owner <= OWN_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_q <= 32'd0;
    end else if (conflict && conflict_q != 32'hFFFF_FFFF) begin
      conflict_q <= conflict_q + 32'd1;
    end
  end

  assign conflict_count = conflict_q;
  assign cpu_rvalid     = (owner == OWN_CPU);
  assign dbg_rvalid     = (owner == OWN_DBG);
  assign cpu_rdata      = cpu_rvalid ? mem_rdata : 32'd0;
  assign dbg_rdata      = dbg_rvalid ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model, policy model checked every cycle,
// plus directed literal expectations.
module tb_dmem_arbiter;

  localparam int AW  = 10;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [3:0]    cpu_be = 4'hF;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [31:0]   dbg_wdata = '0;
  logic [3:0]    dbg_be = 4'hF;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0]   cpu_rdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [31:0]   dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata = '0;
  logic [31:0]   conflict_count;

  int nvec = 0;
  int nerr = 0;

  dmem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_be(dbg_be),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  // Environment RAM: 1-cycle synchronous read, byte-enabled write.
  logic [31:0] ram [1024] = '{default: 32'd0};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Policy model: lost-conflict tally, owed debug slot, pending read return.
  logic [31:0] mmem [1024] = '{default: 32'd0};
  int          m_lost = 0;
  bit          m_owed = 0;
  int          m_pend = 0;
  logic [31:0] m_pdata = '0;
  longint      m_conf = 0;
  bit          pre_set = 0;
  longint      pre_at = 0;

  function automatic void arb(output bit cg, output bit dg);
    cg = 0;
    dg = 0;
    if (rst) begin
      if (cpu_req && dbg_req) begin
        dg = m_owed;
        cg = !m_owed;
      end else begin
        cg = cpu_req;
        dg = dbg_req;
      end
    end
  endfunction

  function automatic logic [31:0] exp_cnt();
    longint v;
    v = pre_set ? 64'hFFFF_FFFE + (m_conf - pre_at) : m_conf;
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  always @(posedge clk or negedge rst) begin
    bit cg, dg;
    if (!rst) begin
      m_lost = 0;
      m_owed = 0;
      m_pend = 0;
      m_conf = 0;
    end else begin
      arb(cg, dg);
      if (cpu_req && dbg_req) m_conf++;
      m_pend = 0;
      if (cg && !cpu_we) begin
        m_pend = 1;
        m_pdata = mmem[cpu_addr];
      end
      if (dg && !dbg_we) begin
        m_pend = 2;
        m_pdata = mmem[dbg_addr];
      end
      for (int b = 0; b < 4; b++) begin
        if (cg && cpu_we && cpu_be[b])
          mmem[cpu_addr][8*b +: 8] = cpu_wdata[8*b +: 8];
        if (dg && dbg_we && dbg_be[b])
          mmem[dbg_addr][8*b +: 8] = dbg_wdata[8*b +: 8];
      end
      if (cpu_req && dbg_req && cg) begin
        m_lost++;
        if (m_lost == LIM) begin
          m_owed = 1;
          m_lost = 0;
        end
      end else if (dg || !dbg_req) begin
        m_lost = 0;
        m_owed = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit cg, dg;
    arb(cg, dg);
    chk("cpu_gnt", 32'(cpu_gnt), 32'(cg));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(dg));
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & !cg));
    chk("mem_en", 32'(mem_en), 32'(cg | dg));
    chk("mem_we", 32'(mem_we), 32'((cg & cpu_we) | (dg & dbg_we)));
    if (cg || dg) begin
      chk("mem_addr", 32'(mem_addr), 32'(dg ? dbg_addr : cpu_addr));
      chk("mem_wdata", mem_wdata, dg ? dbg_wdata : cpu_wdata);
      chk("mem_be", 32'(mem_be), 32'(dg ? dbg_be : cpu_be));
    end
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pend == 1));
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_pend == 2));
    chk("cpu_rdata", cpu_rdata, (m_pend == 1) ? m_pdata : 32'd0);
    chk("dbg_rdata", dbg_rdata, (m_pend == 2) ? m_pdata : 32'd0);
    chk("conflict_count", conflict_count, exp_cnt());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(input logic r, input logic w,
                        input int a, input int d);
    cpu_req = r;
    cpu_we = w;
    cpu_addr = AW'(a);
    cpu_wdata = 32'(d);
  endtask

  task automatic dbg_op(input logic r, input logic w,
                        input int a, input int d);
    dbg_req = r;
    dbg_we = w;
    dbg_addr = AW'(a);
    dbg_wdata = 32'(d);
  endtask

  logic [9:0] gp;

  initial begin
    // Reset with both ports requesting
    cpu_op(1, 0, 0, 0);
    dbg_op(1, 0, 1, 0);
    repeat (2) begin
      @(posedge clk);
      #3;
      chk("rst_gnt", 32'({cpu_gnt, dbg_gnt, mem_en}), 32'd0);
      chk("rst_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
      chk("rst_cnt", conflict_count, 32'd0);
    end
    step();
    rst = 1'b1;
    dbg_op(0, 0, 0, 0);
    #3 chk("first_cpu_gnt", 32'(cpu_gnt), 32'd1);

    // CPU store then load of word 25
    step();
    cpu_op(1, 1, 25, 25);
    #3 chk("st_gnt", 32'({cpu_gnt, cpu_stall}), 32'b10);
    step();
    cpu_op(1, 0, 25, 0);
    #3 chk("ld_gnt", 32'({cpu_gnt, cpu_stall}), 32'b10);
    step();
    cpu_op(0, 0, 0, 0);
    #3 chk("ld_rdata", cpu_rdata, 32'd25);
    chk("ld_rv", 32'({cpu_rvalid, dbg_rvalid}), 32'b10);

    // Debug preload words 0..7 then read back
    for (int i = 0; i < 8; i++) begin
      step();
      dbg_op(1, 1, i, i);
      #3 chk("pre_gnt", 32'(dbg_gnt), 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      dbg_op(1, 0, i, 0);
      #3 chk("rd_gnt", 32'(dbg_gnt), 32'd1);
      if (i > 0) chk("rd_data", dbg_rdata, 32'(i - 1));
    end
    step();
    dbg_op(0, 0, 0, 0);
    #3 chk("rd_last", dbg_rdata, 32'd7);

    // Continuous conflict: debug forced through every 5th cycle
    for (int k = 0; k < 10; k++) begin
      step();
      cpu_op(1, 0, 25, 0);
      dbg_op(1, 0, 3, 0);
      #3 gp[k] = dbg_gnt;
      if (k == 4) chk("starve_stall", 32'(cpu_stall), 32'd1);
    end
    chk("starve_pat", 32'(gp), 32'h210);
    step();
    cpu_op(0, 0, 0, 0);
    dbg_op(0, 0, 0, 0);
    #3 chk("cnt10", conflict_count, 32'd10);

    // Forfeit of the forced slot
    cpu_op(1, 0, 25, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      dbg_op(1, 1, 100, 77);
    end
    step();
    dbg_op(0, 0, 0, 0);
    #3 chk("forfeit_cpu", 32'(cpu_gnt), 32'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      dbg_op(1, 1, 100, 77);
      #3;
      if (k == 0) chk("post_forfeit", 32'(cpu_gnt), 32'd1);
      if (k == 4) chk("post_forfeit_dbg", 32'(dbg_gnt), 32'd1);
    end
    step();
    cpu_op(0, 0, 0, 0);
    dbg_op(0, 0, 0, 0);
    #3 chk("cnt19", conflict_count, 32'd19);

    // Reset during an outstanding CPU load
    step();
    cpu_op(1, 0, 25, 0);
    #3 chk("mid_gnt", 32'(cpu_gnt), 32'd1);
    #3 rst = 1'b0;
    cpu_op(0, 0, 0, 0);
    repeat (2) begin
      @(posedge clk);
      #3 chk("mid_rv", 32'(cpu_rvalid), 32'd0);
    end
    step();
    rst = 1'b1;
    #3 chk("post_rv", 32'(cpu_rvalid), 32'd0);
    chk("post_cnt", conflict_count, 32'd0);

    // Saturation of the conflict counter
    step();
    dut.conflict_q = 32'hFFFF_FFFE;
    pre_at = m_conf;
    pre_set = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      cpu_op(1, 0, 5, 0);
      dbg_op(1, 0, 6, 0);
    end
    step();
    cpu_op(0, 0, 0, 0);
    dbg_op(0, 0, 0, 0);
    #3 chk("sat", conflict_count, 32'hFFFF_FFFF);
    step();
    cpu_op(1, 0, 5, 0);
    dbg_op(1, 0, 6, 0);
    step();
    cpu_op(0, 0, 0, 0);
    dbg_op(0, 0, 0, 0);
    #3 chk("sat_hold", conflict_count, 32'hFFFF_FFFF);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
